// File: rtl/alu_operand_stage.sv
// ID/EX operand stage: forwards EX/MEM and MEM/WB results into the ALU operands,
// inserts bubbles on load-use hazards, and registers the ALU inputs behind a valid/ready handshake.
module alu_operand_stage #(
  parameter int XLEN        = 32,
  parameter int REG_ADDR_W  = 5,
  parameter int STALL_CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [3:0]             in_alu_function,
  input  logic [REG_ADDR_W-1:0]  in_rs1_addr,
  input  logic [REG_ADDR_W-1:0]  in_rs2_addr,
  input  logic [XLEN-1:0]        in_rs1_data,
  input  logic [XLEN-1:0]        in_rs2_data,
  input  logic [XLEN-1:0]        in_imm,
  input  logic                   in_use_imm,
  input  logic [REG_ADDR_W-1:0]  in_rd_addr,
  input  logic                   in_reg_write,
  input  logic                   ex_reg_write,
  input  logic                   ex_is_load,
  input  logic [REG_ADDR_W-1:0]  ex_rd_addr,
  input  logic [XLEN-1:0]        ex_result,
  input  logic                   wb_reg_write,
  input  logic [REG_ADDR_W-1:0]  wb_rd_addr,
  input  logic [XLEN-1:0]        wb_result,
  input  logic                   flush,
  input  logic                   out_ready,
  output logic                   out_valid,
  output logic [3:0]             alu_function,
  output logic [XLEN-1:0]        x,
  output logic [XLEN-1:0]        y,
  output logic [REG_ADDR_W-1:0]  out_rd_addr,
  output logic                   out_reg_write,
  output logic [STALL_CNT_W-1:0] stall_count
);

  // Same encoding as `ALU_ADD in parameters.vh.
  localparam logic [3:0] ALU_ADD = 4'h0;

  logic                   r_out_valid;
  logic [3:0]             r_alu_function;
  logic [XLEN-1:0]        r_x;
  logic [XLEN-1:0]        r_y;
  logic [REG_ADDR_W-1:0]  r_out_rd_addr;
  logic                   r_out_reg_write;
  logic [STALL_CNT_W-1:0] r_stall_count;

  logic [XLEN-1:0]        w_fwd_rs1;
  logic [XLEN-1:0]        w_fwd_rs2;
  logic [XLEN-1:0]        w_x_next;
  logic [XLEN-1:0]        w_y_next;
  logic                   w_hz;
  logic                   w_adv;

  function automatic logic [XLEN-1:0] f_fwd(
    input logic [REG_ADDR_W-1:0] src_addr,
    input logic [XLEN-1:0]       rf_data,
    input logic                  ex_we,
    input logic                  ex_ld,
    input logic [REG_ADDR_W-1:0] ex_rd,
    input logic [XLEN-1:0]       ex_data,
    input logic                  wb_we,
    input logic [REG_ADDR_W-1:0] wb_rd,
    input logic [XLEN-1:0]       wb_data
  );
    logic [XLEN-1:0] v;
    if (src_addr == {REG_ADDR_W{1'b0}}) begin
      v = {XLEN{1'b0}};
    end else if (ex_we && !ex_ld && (ex_rd == src_addr)) begin
      v = ex_data;
    end else if (wb_we && (wb_rd == src_addr)) begin
      v = wb_data;
    end else begin
      v = rf_data;
    end
    return v;
  endfunction

  // Operand forwarding, operand select, hazard detection and handshake.
  always_comb begin
    w_fwd_rs1 = f_fwd(in_rs1_addr, in_rs1_data, ex_reg_write, ex_is_load, ex_rd_addr,
                      ex_result, wb_reg_write, wb_rd_addr, wb_result);
    w_fwd_rs2 = f_fwd(in_rs2_addr, in_rs2_data, ex_reg_write, ex_is_load, ex_rd_addr,
                      ex_result, wb_reg_write, wb_rd_addr, wb_result);
    w_x_next  = w_fwd_rs1;
    if (in_use_imm) begin
      w_y_next = in_imm;
    end else begin
      w_y_next = w_fwd_rs2;
    end
    w_hz = in_valid && ex_reg_write && ex_is_load && (ex_rd_addr != {REG_ADDR_W{1'b0}}) &&
           ((ex_rd_addr == in_rs1_addr) || (!in_use_imm && (ex_rd_addr == in_rs2_addr)));
    w_adv    = !r_out_valid || out_ready;
    in_ready = w_adv && !w_hz && !flush;
  end

  // Pipeline register: flush beats bubble beats load beats drain; otherwise hold.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_out_valid     <= 1'b0;
      r_alu_function  <= ALU_ADD;
      r_x             <= {XLEN{1'b0}};
      r_y             <= {XLEN{1'b0}};
      r_out_rd_addr   <= {REG_ADDR_W{1'b0}};
      r_out_reg_write <= 1'b0;
      r_stall_count   <= {STALL_CNT_W{1'b0}};
    end else if (flush) begin
      r_out_valid     <= 1'b0;
      r_out_reg_write <= 1'b0;
    end else if (w_adv && w_hz) begin
      r_out_valid     <= 1'b0;
      r_out_reg_write <= 1'b0;
      if (r_stall_count != {STALL_CNT_W{1'b1}}) begin
        r_stall_count <= r_stall_count + {{(STALL_CNT_W-1){1'b0}}, 1'b1};
      end
    end else if (w_adv && in_valid) begin
      r_out_valid     <= 1'b1;
      r_alu_function  <= in_alu_function;
      r_x             <= w_x_next;
      r_y             <= w_y_next;
      r_out_rd_addr   <= in_rd_addr;
      r_out_reg_write <= in_reg_write;
    end else if (w_adv) begin
      r_out_valid     <= 1'b0;
      r_out_reg_write <= 1'b0;
    end
  end

  assign out_valid     = r_out_valid;
  assign alu_function  = r_alu_function;
  assign x             = r_x;
  assign y             = r_y;
  assign out_rd_addr   = r_out_rd_addr;
  assign out_reg_write = r_out_reg_write;
  assign stall_count   = r_stall_count;

endmodule

// File: tb/tb_alu_operand_stage.sv
// Directed-vector bench for alu_operand_stage: the driver pushes hand-computed results into a
// scoreboard queue, and a monitor pops and compares whenever the stage hands an instruction on.
module tb_alu_operand_stage;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [3:0]  in_alu_function = 4'h0;
  logic [4:0]  in_rs1_addr = 5'd0;
  logic [4:0]  in_rs2_addr = 5'd0;
  logic [31:0] in_rs1_data = 32'h0;
  logic [31:0] in_rs2_data = 32'h0;
  logic [31:0] in_imm = 32'h0;
  logic        in_use_imm = 1'b0;
  logic [4:0]  in_rd_addr = 5'd0;
  logic        in_reg_write = 1'b0;
  logic        ex_reg_write = 1'b0;
  logic        ex_is_load = 1'b0;
  logic [4:0]  ex_rd_addr = 5'd0;
  logic [31:0] ex_result = 32'h0;
  logic        wb_reg_write = 1'b0;
  logic [4:0]  wb_rd_addr = 5'd0;
  logic [31:0] wb_result = 32'h0;
  logic        flush = 1'b0;
  logic        out_ready = 1'b1;
  logic        out_valid;
  logic [3:0]  alu_function;
  logic [31:0] x;
  logic [31:0] y;
  logic [4:0]  out_rd_addr;
  logic        out_reg_write;
  logic [15:0] stall_count;

  typedef struct packed {
    logic [3:0]  f;
    logic [31:0] x;
    logic [31:0] y;
    logic [4:0]  rd;
    logic        rw;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  alu_operand_stage dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_alu_function(in_alu_function), .in_rs1_addr(in_rs1_addr), .in_rs2_addr(in_rs2_addr),
    .in_rs1_data(in_rs1_data), .in_rs2_data(in_rs2_data), .in_imm(in_imm),
    .in_use_imm(in_use_imm), .in_rd_addr(in_rd_addr), .in_reg_write(in_reg_write),
    .ex_reg_write(ex_reg_write), .ex_is_load(ex_is_load), .ex_rd_addr(ex_rd_addr),
    .ex_result(ex_result), .wb_reg_write(wb_reg_write), .wb_rd_addr(wb_rd_addr),
    .wb_result(wb_result), .flush(flush), .out_ready(out_ready), .out_valid(out_valid),
    .alu_function(alu_function), .x(x), .y(y), .out_rd_addr(out_rd_addr),
    .out_reg_write(out_reg_write), .stall_count(stall_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [3:0] f, input logic [31:0] ex, input logic [31:0] ey,
                      input logic [4:0] rd, input logic rw);
    exp_t e;
    e.f = f; e.x = ex; e.y = ey; e.rd = rd; e.rw = rw;
    sb.push_back(e);
  endtask

  task automatic set_in(input logic v, input logic [3:0] f, input logic [4:0] rs1,
                        input logic [31:0] d1, input logic [4:0] rs2, input logic [31:0] d2,
                        input logic [31:0] imm, input logic ui, input logic [4:0] rd,
                        input logic rw);
    in_valid = v; in_alu_function = f; in_rs1_addr = rs1; in_rs1_data = d1;
    in_rs2_addr = rs2; in_rs2_data = d2; in_imm = imm; in_use_imm = ui;
    in_rd_addr = rd; in_reg_write = rw;
  endtask

  task automatic clr_bypass();
    ex_reg_write = 1'b0; ex_is_load = 1'b0; ex_rd_addr = 5'd0; ex_result = 32'h0;
    wb_reg_write = 1'b0; wb_rd_addr = 5'd0; wb_result = 32'h0;
  endtask

  // Monitor: every downstream transfer must match the oldest expected entry.
  always @(negedge clk) begin
    if (!reset) begin
      if (!out_valid) chk("rw_zero_when_invalid", 64'(out_reg_write), 64'd0);
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_output actual=x:%0h y:%0h expected=nothing", x, y);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("sb_func", 64'(alu_function), 64'(e.f));
          chk("sb_x", 64'(x), 64'(e.x));
          chk("sb_y", 64'(y), 64'(e.y));
          chk("sb_rd", 64'(out_rd_addr), 64'(e.rd));
          chk("sb_rw", 64'(out_reg_write), 64'(e.rw));
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    cyc();
    cyc();
    chk("rst_valid", 64'(out_valid), 64'd0);
    chk("rst_func", 64'(alu_function), 64'h0);
    chk("rst_x", 64'(x), 64'd0);
    chk("rst_y", 64'(y), 64'd0);
    chk("rst_rd", 64'(out_rd_addr), 64'd0);
    chk("rst_rw", 64'(out_reg_write), 64'd0);
    chk("rst_stall", 64'(stall_count), 64'd0);
    #2 reset = 1'b0;
    cyc();

    // Plain register operands
    set_in(1'b1, 4'h0, 5'd1, 32'd5, 5'd2, 32'd7, 32'h0, 1'b0, 5'd5, 1'b1);
    #1 chk("basic_ready", 64'(in_ready), 64'd1);
    push(4'h0, 32'd5, 32'd7, 5'd5, 1'b1);
    cyc();

    // EX beats WB, then WB alone
    ex_reg_write = 1'b1; ex_rd_addr = 5'd3; ex_result = 32'h100;
    wb_reg_write = 1'b1; wb_rd_addr = 5'd3; wb_result = 32'h200;
    set_in(1'b1, 4'h1, 5'd3, 32'h33, 5'd0, 32'h77, 32'h0, 1'b0, 5'd6, 1'b1);
    #1 chk("ex_prio_ready", 64'(in_ready), 64'd1);
    push(4'h1, 32'h100, 32'h0, 5'd6, 1'b1);
    cyc();
    ex_reg_write = 1'b0;
    push(4'h1, 32'h200, 32'h0, 5'd6, 1'b1);
    cyc();

    // x0 reads as zero despite data and a matching forward
    ex_reg_write = 1'b1; ex_rd_addr = 5'd0; ex_result = 32'd9;
    wb_reg_write = 1'b1; wb_rd_addr = 5'd0; wb_result = 32'd3;
    set_in(1'b1, 4'h2, 5'd0, 32'hDEAD, 5'd0, 32'hBEEF, 32'h0, 1'b0, 5'd7, 1'b0);
    push(4'h2, 32'h0, 32'h0, 5'd7, 1'b0);
    cyc();

    // Immediate masks a load on rs2: no forward, no stall
    clr_bypass();
    ex_reg_write = 1'b1; ex_is_load = 1'b1; ex_rd_addr = 5'd7; ex_result = 32'h55;
    set_in(1'b1, 4'h0, 5'd1, 32'h11, 5'd7, 32'h70, 32'hFFFFFFFC, 1'b1, 5'd8, 1'b1);
    #1 chk("imm_no_stall_ready", 64'(in_ready), 64'd1);
    push(4'h0, 32'h11, 32'hFFFFFFFC, 5'd8, 1'b1);
    cyc();

    // WB forward on rs2
    clr_bypass();
    wb_reg_write = 1'b1; wb_rd_addr = 5'd9; wb_result = 32'hABC;
    set_in(1'b1, 4'h3, 5'd2, 32'h22, 5'd9, 32'h99, 32'h0, 1'b0, 5'd10, 1'b1);
    push(4'h3, 32'h22, 32'hABC, 5'd10, 1'b1);
    cyc();

    // Load-use on rs2: one bubble, then forwarded result
    clr_bypass();
    ex_reg_write = 1'b1; ex_is_load = 1'b1; ex_rd_addr = 5'd4; ex_result = 32'hEE;
    set_in(1'b1, 4'h0, 5'd1, 32'd1, 5'd4, 32'h44, 32'h0, 1'b0, 5'd11, 1'b1);
    #1 chk("hz_ready", 64'(in_ready), 64'd0);
    cyc();
    chk("hz_bubble_valid", 64'(out_valid), 64'd0);
    chk("hz_stall_count", 64'(stall_count), 64'd1);
    ex_is_load = 1'b0; ex_result = 32'd11;
    #1 chk("hz_release_ready", 64'(in_ready), 64'd1);
    push(4'h0, 32'd1, 32'd11, 5'd11, 1'b1);
    cyc();
    clr_bypass();
    in_valid = 1'b0;
    cyc();
    chk("stall_count_kept", 64'(stall_count), 64'd1);

    // Downstream back-pressure holds outputs for 3 cycles
    set_in(1'b1, 4'h4, 5'd1, 32'hA1, 5'd2, 32'hA2, 32'h0, 1'b0, 5'd12, 1'b1);
    push(4'h4, 32'hA1, 32'hA2, 5'd12, 1'b1);
    cyc();
    out_ready = 1'b0;
    set_in(1'b1, 4'h5, 5'd1, 32'hB1, 5'd2, 32'hB2, 32'h0, 1'b0, 5'd13, 1'b0);
    for (int i = 0; i < 3; i++) begin
      #1 chk("hold_ready", 64'(in_ready), 64'd0);
      chk("hold_valid", 64'(out_valid), 64'd1);
      chk("hold_x", 64'(x), 64'hA1);
      chk("hold_func", 64'(alu_function), 64'h4);
      cyc();
    end
    out_ready = 1'b1;
    #1 chk("release_ready", 64'(in_ready), 64'd1);
    push(4'h5, 32'hB1, 32'hB2, 5'd13, 1'b0);
    cyc();
    in_valid = 1'b0;
    chk("release_x", 64'(x), 64'hB1);
    cyc();

    // Flush kills the incoming instruction
    set_in(1'b1, 4'h6, 5'd1, 32'hC1, 5'd2, 32'hC2, 32'h0, 1'b0, 5'd14, 1'b1);
    push(4'h6, 32'hC1, 32'hC2, 5'd14, 1'b1);
    cyc();
    set_in(1'b1, 4'h7, 5'd1, 32'hD1, 5'd2, 32'hD2, 32'h0, 1'b0, 5'd15, 1'b1);
    flush = 1'b1;
    #1 chk("flush_ready", 64'(in_ready), 64'd0);
    cyc();
    flush = 1'b0;
    in_valid = 1'b0;
    chk("flush_valid", 64'(out_valid), 64'd0);
    chk("flush_rw", 64'(out_reg_write), 64'd0);
    cyc();

    // Async reset mid-stream
    set_in(1'b1, 4'h8, 5'd1, 32'hE1, 5'd2, 32'hE2, 32'h0, 1'b0, 5'd16, 1'b1);
    cyc();
    in_valid = 1'b0;
    out_ready = 1'b0;
    #2 reset = 1'b1;
    #1 chk("arst_valid", 64'(out_valid), 64'd0);
    chk("arst_x", 64'(x), 64'd0);
    chk("arst_rw", 64'(out_reg_write), 64'd0);
    chk("arst_stall", 64'(stall_count), 64'd0);
    #3 reset = 1'b0;
    out_ready = 1'b1;
    cyc();

    // First accept after reset
    set_in(1'b1, 4'h9, 5'd1, 32'hF1, 5'd2, 32'hF2, 32'h0, 1'b0, 5'd17, 1'b1);
    push(4'h9, 32'hF1, 32'hF2, 5'd17, 1'b1);
    cyc();
    in_valid = 1'b0;
    cyc();
    cyc();
    chk("sb_drained", 64'(sb.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_operand_stage.md
Name: alu_operand_stage

Overview:
- ID/EX pipeline stage directly upstream of the ALU.
- Takes decoded instruction fields and register-file read data, and resolves operand forwarding from the EX/MEM and MEM/WB stages.
- Detects load-use hazards and inserts bubbles when one occurs.
- Registers the ALU control code and both operands so they drive the ALU inputs alu_function, x and y directly.
- Uses a valid/ready handshake with stall and flush support.

Parameters:
- XLEN, 32, operand/data width
- REG_ADDR_W, 5, register address width
- STALL_CNT_W, 16, width of the saturating load-use stall counter

Ports:
- clk  input  1  clock; all state updates on the rising edge
- reset  input  1  asynchronous, active-high reset
- in_valid  input  1  decoded instruction present
- in_ready  output  1  stage accepts the instruction this cycle
- in_alu_function  input  4  ALU operation code (`ALU_* encodings from parameters.vh)
- in_rs1_addr  input  REG_ADDR_W  source register 1
- in_rs2_addr  input  REG_ADDR_W  source register 2
- in_rs1_data  input  XLEN  register-file read data for rs1
- in_rs2_data  input  XLEN  register-file read data for rs2
- in_imm  input  XLEN  sign-extended immediate
- in_use_imm  input  1  1: y comes from the immediate; 0: y comes from rs2
- in_rd_addr  input  REG_ADDR_W  destination register
- in_reg_write  input  1  instruction writes rd
- ex_reg_write  input  1  EX/MEM stage writes a register
- ex_is_load  input  1  EX/MEM instruction is a load (its data is not yet available)
- ex_rd_addr  input  REG_ADDR_W  EX/MEM destination register
- ex_result  input  XLEN  EX/MEM result
- wb_reg_write  input  1  MEM/WB stage writes a register
- wb_rd_addr  input  REG_ADDR_W  MEM/WB destination register
- wb_result  input  XLEN  MEM/WB write-back data
- flush  input  1  kill the held and incoming instruction (branch redirect)
- out_ready  input  1  downstream ALU stage can accept
- out_valid  output  1  registered operands are valid
- alu_function  output  4  registered operation code, to the ALU
- x  output  XLEN  registered operand 1, to the ALU
- y  output  XLEN  registered operand 2, to the ALU
- out_rd_addr  output  REG_ADDR_W  registered destination register
- out_reg_write  output  1  registered write enable; 0 whenever out_valid is 0
- stall_count  output  STALL_CNT_W  number of load-use stall cycles, saturating

Behaviour:
- Reset (asynchronous): out_valid=0, alu_function=`ALU_ADD, x=0, y=0, out_rd_addr=0, out_reg_write=0, stall_count=0.
- Forwarding (combinational) for each source s in {rs1, rs2}:
  - s_addr==0 gives 0; this overrides in_rsX_data and any forward.
  - Otherwise, if ex_reg_write && !ex_is_load && ex_rd_addr==s_addr, use ex_result.
  - Otherwise, if wb_reg_write && wb_rd_addr==s_addr, use wb_result.
  - Otherwise use in_rsX_data.
  - EX has priority over WB.
- Operand select: x_next = fwd(rs1); y_next = in_use_imm ? in_imm : fwd(rs2).
- Load-use hazard, hz:
  - hz = in_valid && ex_reg_write && ex_is_load && ex_rd_addr!=0 && (ex_rd_addr==in_rs1_addr || (!in_use_imm && ex_rd_addr==in_rs2_addr)).
- Advance condition: adv = !out_valid || out_ready.
- Handshake: in_ready = adv && !hz && !flush.
- Register update on clk rising edge, in priority order:
  1. flush: out_valid<=0, out_reg_write<=0, whether or not the stage is advancing.
  2. adv && hz: insert a bubble. out_valid<=0, out_reg_write<=0. The instruction is not consumed; upstream holds it. stall_count increments.
  3. adv && in_valid: load alu_function, x, y, out_rd_addr, out_reg_write=in_reg_write; out_valid<=1.
  4. adv && !in_valid: out_valid<=0, out_reg_write<=0.
  5. !adv: hold all outputs (stall by downstream).
- Data outputs other than out_valid/out_reg_write may retain stale values while out_valid=0.
- Latency: 1 cycle from an accepted input to out_valid. Throughput: 1 instruction per cycle when out_ready=1 and there is no hazard.
- stall_count counts only cycles where adv && hz && !flush, and saturates at 2^STALL_CNT_W-1.
- Reset asserted mid-operation forces the reset values immediately, independent of clk. The first accept is possible on the first clk edge after reset deasserts.

Test Plan:
- Reset, then in_valid=1, ADD, rs1=1 (data 5), rs2=2 (data 7), use_imm=0, out_ready=1 → next cycle out_valid=1, x=5, y=7, alu_function=`ALU_ADD.
- rs1=3, ex_reg_write=1, ex_rd=3, ex_result=0x100; wb_reg_write=1, wb_rd=3, wb_result=0x200 → x=0x100 (EX priority). Repeat with ex_reg_write=0 → x=0x200.
- rs1=0, in_rs1_data=0xDEAD, ex_rd=0, ex_result=9 → x=0. use_imm=1, imm=0xFFFFFFFC, rs2 matching ex_rd → y=0xFFFFFFFC, no forward, no stall.
- ex_is_load=1, ex_rd=4, in rs2=4, use_imm=0 → in_ready=0, bubble (out_valid=0), stall_count=1. Next cycle ex_is_load=0, ex_result=11 → accepted, y=11.
- out_valid=1, out_ready=0 for 3 cycles with a new in_valid → in_ready=0, outputs held unchanged. Then out_ready=1 → new instruction appears 1 cycle later.
- flush=1 with in_valid=1 and out_valid=1 → next cycle out_valid=0, out_reg_write=0, in_ready=0 during flush. Async reset pulse mid-stream → immediate reset values, stall_count=0.
